// File: rtl/packet_deframer.sv
// UART packet deframer: strips SYNC/Dest/Source/Length headers and streams the
// payload as SoP/EoP-delimited beats, dropping frames on zero length or inter-byte timeout.
package packet_deframer_pkg;
   typedef struct packed {
      logic [7:0] Source;
      logic [7:0] Destination;
      logic [7:0] Length;
      logic       SoP;
      logic       EoP;
      logic [7:0] Data;
      logic       Valid;
   } UART_PACKET;
endpackage

module packet_deframer
   import packet_deframer_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'h55,
   parameter int         TIMEOUT_CYCLES = 5000
)(
   input  logic       ipClk,
   input  logic       reset,
   input  logic [7:0] ipRxData,
   input  logic       ipRxValid,
   output UART_PACKET opRxStream,
   output logic       opFrameError
);

   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      GET_DEST,
      GET_SOURCE,
      GET_LENGTH,
      GET_DATA
   } stateType;

   stateType    state;
   logic [7:0]  destShadow;
   logic [7:0]  sourceShadow;
   logic [7:0]  remaining;
   logic [15:0] idleCount;

   // Header bytes go to shadow registers first so the visible header only
   // changes when the next frame's Length byte arrives.
   always_ff @(posedge ipClk) begin
      if (reset) begin
         state        <= IDLE;
         destShadow   <= '0;
         sourceShadow <= '0;
         remaining    <= '0;
         idleCount    <= '0;
         opRxStream   <= '0;
         opFrameError <= 1'b0;
      end else begin
         opRxStream.Valid <= 1'b0;
         opRxStream.SoP   <= 1'b0;
         opRxStream.EoP   <= 1'b0;
         opFrameError     <= 1'b0;

         if (ipRxValid || state == IDLE)
            idleCount <= '0;
         else
            idleCount <= idleCount + 16'd1;

         if (ipRxValid) begin
            case (state)
               IDLE: begin
                  if (ipRxData == SYNC_BYTE)
                     state <= GET_DEST;
               end
               GET_DEST: begin
                  destShadow <= ipRxData;
                  state      <= GET_SOURCE;
               end
               GET_SOURCE: begin
                  sourceShadow <= ipRxData;
                  state        <= GET_LENGTH;
               end
               GET_LENGTH: begin
                  opRxStream.Destination <= destShadow;
                  opRxStream.Source      <= sourceShadow;
                  opRxStream.Length      <= ipRxData;
                  remaining              <= ipRxData;
                  if (ipRxData == 8'd0) begin
                     state        <= IDLE;
                     opFrameError <= 1'b1;
                  end else begin
                     state <= GET_DATA;
                  end
               end
               GET_DATA: begin
                  opRxStream.Valid <= 1'b1;
                  opRxStream.Data  <= ipRxData;
                  opRxStream.SoP   <= (remaining == opRxStream.Length);
                  opRxStream.EoP   <= (remaining == 8'd1);
                  if (remaining != 8'd0)
                     remaining <= remaining - 8'd1;
                  if (remaining <= 8'd1)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && idleCount == TIMEOUT_VAL) begin
            // A received byte in the same cycle wins over the timeout.
            state        <= IDLE;
            opFrameError <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_packet_deframer.sv
// Directed-vector bench for packet_deframer: frames, discards, zero length,
// timeout, timeout/byte race and mid-frame reset.
module tb_packet_deframer;
   import packet_deframer_pkg::*;

   localparam int TIMEOUT = 20;

   typedef logic [7:0] byteQueue[$];
   typedef struct {
      logic [7:0] data;
      logic [7:0] dst;
      logic [7:0] src;
      logic [7:0] len;
      logic       sop;
      logic       eop;
   } beatRec;

   logic       ipClk     = 1'b0;
   logic       reset     = 1'b1;
   logic [7:0] ipRxData  = 8'h00;
   logic       ipRxValid = 1'b0;
   UART_PACKET opRxStream;
   logic       opFrameError;

   beatRec beats[$];
   beatRec monRec;
   int errPulses  = 0;
   int strayFlags = 0;
   int vectorCount = 0;
   int missCount   = 0;
   int beatBase, errBase, strayBase;

   packet_deframer #(
      .SYNC_BYTE      (8'h55),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .ipClk        (ipClk),
      .reset        (reset),
      .ipRxData     (ipRxData),
      .ipRxValid    (ipRxValid),
      .opRxStream   (opRxStream),
      .opFrameError (opFrameError)
   );

   always #5 ipClk = ~ipClk;

   // Outputs only move on the rising edge, so the falling edge is a safe sample point.
   always @(negedge ipClk) begin
      if (opRxStream.Valid) begin
         monRec.data = opRxStream.Data;
         monRec.dst  = opRxStream.Destination;
         monRec.src  = opRxStream.Source;
         monRec.len  = opRxStream.Length;
         monRec.sop  = opRxStream.SoP;
         monRec.eop  = opRxStream.EoP;
         beats.push_back(monRec);
         $display("beat data=%02h dst=%02h src=%02h len=%02h sop=%0b eop=%0b",
                  monRec.data, monRec.dst, monRec.src, monRec.len, monRec.sop, monRec.eop);
      end
      if (opFrameError) begin
         errPulses++;
         $display("frame error pulse at %0t", $time);
      end
      if (!opRxStream.Valid && (opRxStream.SoP || opRxStream.EoP))
         strayFlags++;
   end

   task automatic checkValue(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(negedge ipClk);
      ipRxData  = b;
      ipRxValid = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge ipClk);
         ipRxValid = 1'b0;
      end
   endtask

   task automatic sendSeq(input byteQueue bytes, input int spacing);
      foreach (bytes[i]) begin
         sendByte(bytes[i]);
         if (spacing > 0) gap(spacing);
      end
   endtask

   task automatic markStart();
      beatBase  = beats.size();
      errBase   = errPulses;
      strayBase = strayFlags;
   endtask

   task automatic settle();
      gap(3);
      #1;
   endtask

   task automatic checkBeat(input string tag, input int idx, input logic [7:0] data,
                            input logic sop, input logic eop, input logic [7:0] dst,
                            input logic [7:0] src, input logic [7:0] len);
      beatRec b;
      b = beats[beatBase + idx];
      checkValue({tag, "_data"}, 64'(b.data), 64'(data));
      checkValue({tag, "_sop"},  64'(b.sop),  64'(sop));
      checkValue({tag, "_eop"},  64'(b.eop),  64'(eop));
      checkValue({tag, "_dst"},  64'(b.dst),  64'(dst));
      checkValue({tag, "_src"},  64'(b.src),  64'(src));
      checkValue({tag, "_len"},  64'(b.len),  64'(len));
   endtask

   task automatic checkCounts(input string tag, input int nBeats, input int nErr);
      checkValue({tag, "_beats"}, 64'(beats.size() - beatBase), 64'(nBeats));
      checkValue({tag, "_errs"},  64'(errPulses - errBase),     64'(nErr));
      checkValue({tag, "_stray"}, 64'(strayFlags - strayBase),  64'(0));
   endtask

   initial begin
      // Reset state, and a SYNC byte presented during reset must be ignored.
      repeat (3) @(negedge ipClk);
      checkValue("rst_stream", 64'(opRxStream), 64'(0));
      checkValue("rst_err",    64'(opFrameError), 64'(0));
      ipRxData  = 8'h55;
      ipRxValid = 1'b1;
      @(negedge ipClk);
      reset     = 1'b0;
      ipRxValid = 1'b0;
      markStart();
      sendSeq('{8'h01, 8'h02, 8'h01, 8'h77}, 0);
      settle();
      checkCounts("rst_sync", 0, 0);

      // Back-to-back four-byte frame.
      markStart();
      sendSeq('{8'h55, 8'h01, 8'hAB, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
      settle();
      checkCounts("f4", 4, 0);
      checkBeat("f4_b0", 0, 8'h11, 1'b1, 1'b0, 8'h01, 8'hAB, 8'h04);
      checkBeat("f4_b1", 1, 8'h22, 1'b0, 1'b0, 8'h01, 8'hAB, 8'h04);
      checkBeat("f4_b2", 2, 8'h33, 1'b0, 1'b0, 8'h01, 8'hAB, 8'h04);
      checkBeat("f4_b3", 3, 8'h44, 1'b0, 1'b1, 8'h01, 8'hAB, 8'h04);

      // Leading junk discarded; SYNC value as payload on a Length=1 frame.
      markStart();
      sendSeq('{8'h00, 8'h7F, 8'h55, 8'h02, 8'h03, 8'h01, 8'h55}, 1);
      settle();
      checkCounts("f1", 1, 0);
      checkBeat("f1_b0", 0, 8'h55, 1'b1, 1'b1, 8'h02, 8'h03, 8'h01);

      // Zero length: single error pulse right after the 00 byte, then recovery.
      markStart();
      sendSeq('{8'h55, 8'h01, 8'h02, 8'h00}, 0);
      gap(1);
      checkValue("len0_pulse", 64'(opFrameError), 64'(1));
      gap(1);
      checkValue("len0_pulse_end", 64'(opFrameError), 64'(0));
      settle();
      checkCounts("len0", 0, 1);
      checkValue("len0_hdr_len", 64'(opRxStream.Length), 64'(0));
      markStart();
      sendSeq('{8'h55, 8'h01, 8'h02, 8'h01, 8'hC3}, 0);
      settle();
      checkCounts("len0_next", 1, 0);
      checkBeat("len0_next_b0", 0, 8'hC3, 1'b1, 1'b1, 8'h01, 8'h02, 8'h01);

      // Timeout mid-frame: error exactly TIMEOUT+1 cycles after the last byte's edge.
      markStart();
      sendSeq('{8'h55, 8'h01, 8'h02, 8'h03, 8'hAA}, 0);
      gap(TIMEOUT + 1);
      checkValue("tmo_early", 64'(opFrameError), 64'(0));
      gap(1);
      checkValue("tmo_pulse", 64'(opFrameError), 64'(1));
      gap(1);
      checkValue("tmo_pulse_end", 64'(opFrameError), 64'(0));
      settle();
      checkCounts("tmo", 1, 1);
      checkBeat("tmo_b0", 0, 8'hAA, 1'b1, 1'b0, 8'h01, 8'h02, 8'h03);
      markStart();
      sendSeq('{8'h55, 8'h01, 8'h02, 8'h01, 8'hBB}, 0);
      settle();
      checkCounts("tmo_next", 1, 0);
      checkBeat("tmo_next_b0", 0, 8'hBB, 1'b1, 1'b1, 8'h01, 8'h02, 8'h01);

      // Byte lands in the very cycle the idle counter reaches the timeout.
      markStart();
      sendSeq('{8'h55, 8'h05, 8'h06, 8'h03, 8'hAA}, 0);
      gap(TIMEOUT);
      sendByte(8'h55);
      sendByte(8'h66);
      settle();
      checkCounts("race", 3, 0);
      checkBeat("race_b1", 1, 8'h55, 1'b0, 1'b0, 8'h05, 8'h06, 8'h03);
      checkBeat("race_b2", 2, 8'h66, 1'b0, 1'b1, 8'h05, 8'h06, 8'h03);

      // Reset after the second data byte of a Length=4 frame.
      markStart();
      sendSeq('{8'h55, 8'h01, 8'h02, 8'h04, 8'h11, 8'h22}, 0);
      @(negedge ipClk);
      reset     = 1'b1;
      ipRxValid = 1'b0;
      @(negedge ipClk);
      checkValue("mid_rst_stream", 64'(opRxStream), 64'(0));
      checkValue("mid_rst_err",    64'(opFrameError), 64'(0));
      @(negedge ipClk);
      reset = 1'b0;
      sendSeq('{8'h33, 8'h44, 8'h55, 8'h09, 8'h08, 8'h02, 8'hD1, 8'hD2}, 0);
      settle();
      checkCounts("mid_rst", 4, 0);
      checkBeat("mid_rst_b1", 1, 8'h22, 1'b0, 1'b0, 8'h01, 8'h02, 8'h04);
      checkBeat("mid_rst_b2", 2, 8'hD1, 1'b1, 1'b0, 8'h09, 8'h08, 8'h02);
      checkBeat("mid_rst_b3", 3, 8'hD2, 1'b0, 1'b1, 8'h09, 8'h08, 8'h02);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h55, the byte value that starts a frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, the inter-byte timeout in ipClk cycles; legal range 2..65535.
REQ-003 SHALL have port ipClk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock ipClk.
REQ-005 SHALL have port ipRxData  input  8  received UART byte, qualified by ipRxValid.
REQ-006 SHALL have port ipRxValid  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port opRxStream  output  UART_PACKET  fields Source[7:0], Destination[7:0], Length[7:0], SoP, EoP, Data[7:0], Valid.
REQ-008 SHALL have port opFrameError  output  1  one-cycle pulse on a dropped or aborted frame.

Function
REQ-009 SHALL parse frames in this order: SYNC_BYTE, Destination, Source, Length, then Length data bytes.
REQ-010 SHALL use FSM states IDLE, GET_DEST, GET_SOURCE, GET_LENGTH, GET_DATA.
REQ-011 SHALL advance state only on cycles with ipRxValid=1: IDLE->GET_DEST on SYNC_BYTE; GET_DEST->GET_SOURCE; GET_SOURCE->GET_LENGTH; GET_LENGTH->GET_DATA if byte!=0.
REQ-012 SHALL discard every non-SYNC_BYTE byte received in IDLE, with no output and no error.
REQ-013 SHALL treat a SYNC_BYTE value received in any state other than IDLE as ordinary header or data content; no resynchronisation.
REQ-014 SHALL latch Destination, Source and Length into registers and hold them stable on opRxStream from GET_LENGTH completion until the next frame's GET_LENGTH byte.
REQ-015 SHALL, on Length byte = 0, return to IDLE, emit no Valid beat, and pulse opFrameError for one cycle.
REQ-016 SHALL, in GET_DATA, emit exactly one beat per received data byte with Valid=1 and Data=ipRxData, registered one cycle after the ipRxValid cycle (latency 1).
REQ-017 SHALL assert SoP=1 on the first data beat only and EoP=1 on the Length-th beat only; Length=1 gives SoP=EoP=1 on a single beat.
REQ-018 SHALL drive Valid, SoP and EoP low on every cycle without a data beat.
REQ-019 SHALL return to IDLE in the same cycle the EoP beat is registered; a SYNC_BYTE on the next ipRxValid starts a new frame.
REQ-020 SHALL count data bytes with an 8-bit down-counter loaded from Length; no wrap past zero.
REQ-021 SHALL keep a 16-bit idle counter, cleared on every ipRxValid and held at zero in IDLE, otherwise incremented each cycle.
REQ-022 SHALL, when the idle counter reaches TIMEOUT_CYCLES outside IDLE, go to IDLE, pulse opFrameError for one cycle, and emit no EoP beat.
REQ-023 SHALL give ipRxValid priority over timeout in the same cycle: the byte is processed, the counter clears, and no error is raised.
REQ-024 SHALL accept back-to-back ipRxValid on consecutive cycles with no byte loss; no backpressure exists.

Reset
REQ-025 SHALL, while reset=1, force state IDLE, counters 0, opFrameError 0, and all opRxStream fields 0, including Valid, SoP and EoP.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame with no EoP and no error pulse; the first byte after reset is parsed from IDLE.
REQ-027 SHALL ignore ipRxValid in a cycle where reset=1.

Verification
REQ-028 Bytes 55,01,AB,04,11,22,33,44 -> 4 beats Data 11,22,33,44; SoP on 11, EoP on 44; Source=AB, Destination=01, Length=04 on all beats.
REQ-029 Bytes 00,7F,55,02,03,01,55 -> leading 00,7F discarded; one beat Data=55 with SoP=EoP=1, Destination=02, Source=03.
REQ-030 Bytes 55,01,02,00 -> no beat; opFrameError high for exactly one cycle after the 00 byte; the next 55 starts a new frame.
REQ-031 Bytes 55,01,02,03,AA, then silence for TIMEOUT_CYCLES -> beat AA with SoP, no EoP, one opFrameError pulse; then 55,01,02,01,BB -> beat BB with SoP=EoP=1.
REQ-032 Byte 55 arriving in the same cycle the idle counter hits TIMEOUT_CYCLES in GET_DATA -> processed as data, no opFrameError.
REQ-033 reset pulsed after the 2nd data byte of a Length=4 frame -> outputs zero during reset, no further beats; a fresh frame afterwards decodes correctly.
